mult_div_unit: RTL
==================

# mult_div_unit

Iterative multiply/divide unit with HI/LO registers for the pipelined MIPS core. It adds MULT, MULTU, DIV, DIVU, MFHI/MFLO sourcing and MTHI/MTLO to the instruction set, and is parametrised in datapath width. It sits beside the ALU in the EX stage. The pipeline controller stalls the front end while `busy` is high.

## Interface
- `NBits`, 32, operand/HI/LO width; must be ≥ 4 and even.
- `clk`  in  1  clock; rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new operation; sampled only in IDLE.
- `op`  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `OperandA`  in  NBits  multiplicand or dividend (rs).
- `OperandB`  in  NBits  multiplier or divisor (rt).
- `flush`  in  1  abort the in-flight operation (branch/jump taken in WB).
- `hi_we`  in  1  MTHI write enable.
- `lo_we`  in  1  MTLO write enable.
- `WriteData`  in  NBits  MTHI/MTLO data.
- `busy`  out  1  operation in flight; EX must stall.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- `div_by_zero`  out  1  pulses with `done` when a divide had OperandB = 0.
- `HI`  out  NBits  HI register (product high half or remainder).
- `LO`  out  NBits  LO register (product low half or quotient).

## Operation
- FSM states and transitions:
  - IDLE: `start & ~flush` → CALC. On entry, latch magnitudes of A and B (two's-complement abs for MULT/DIV; raw for unsigned), the result signs, `op`, and clear the iteration counter.
  - CALC: one radix-2 step per cycle for NBits cycles, then → SIGN.
    - Multiply: shift-add into a 2·NBits accumulator.
    - Divide: restoring shift-subtract; the remainder register is NBits+1 bits wide.
  - SIGN: apply sign correction, write HI/LO, register `done` and `div_by_zero`, then → IDLE.
- Signed multiply: negate the 2·NBits product if the operand signs differ.
- Signed divide rules:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Most-negative / −1 gives LO = most-negative value, HI = 0; no exception.
- Divide by zero, any signedness:
  - LO = all ones, HI = OperandA as latched.
  - Sign correction is skipped.
  - `div_by_zero` = 1 alongside `done`.
- Request handling:
  - `start` while busy is ignored; it is not queued.
  - `start` and `flush` in the same IDLE cycle: flush wins, nothing starts.
- `flush` in CALC or SIGN:
  - Next state is IDLE.
  - HI/LO keep their prior values.
  - No `done`, no `div_by_zero`.
- MTHI/MTLO:
  - `hi_we`/`lo_we` write HI/LO at the next edge only in IDLE; ignored while busy.
  - A write in the same cycle as an accepted `start` is applied; the later result overwrites it.
  - A write during the `done` cycle is applied, since the FSM is already back in IDLE.

## Timing
- Reset values: state IDLE, HI = 0, LO = 0, `busy` = 0, `done` = 0, `div_by_zero` = 0, counter = 0. Reset takes effect immediately (async), even mid-operation.
- Cycle sequence, with `start` high in cycle 0:
  - Cycles 1 .. NBits+1: `busy` = 1 (NBits CALC cycles plus the SIGN cycle).
  - Cycle NBits+2: `done` = 1, `busy` = 0, HI/LO updated. For NBits = 32, `done` is in cycle 34.
- Back-to-back: a new `start` may be asserted in the `done` cycle.
- `busy` is registered, and equals (state ≠ IDLE).
- HI/LO are registered outputs; no combinational path from any input to any output.

## Structure
- Package `mdu_pkg` holds:
  - op encodings: `MDU_MULTU`, `MDU_MULT`, `MDU_DIVU`, `MDU_DIV`;
  - FSM state encoding: `IDLE`, `CALC`, `SIGN`;
  - counter width `$clog2(NBits)+1`.
- One natural sub-module, `mdu_step`: combinational single-iteration datapath (add-or-pass for multiply, trial subtract for divide), parametrised on NBits. The FSM, counter, and HI/LO registers stay in `mult_div_unit`.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001; `done` exactly in cycle 34; `busy` high in cycles 1–33.
- MULT −3 × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 100 / 0 → LO = 0xFFFFFFFF, HI = 0x00000064, `div_by_zero` = 1 with `done`. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- After an MTHI of 0x12345678, start MULTU 5 × 5; assert `flush` in cycle 10 → no `done`; HI = 0x12345678 retained; second `start` in cycle 5 ignored.
- Drop `reset` low in cycle 20 of a DIVU → all outputs return to zero immediately; after release, a fresh MULTU 6 × 7 gives LO = 42, HI = 0.
- NBits = 8 instance: MULT 0x80 × 0x80 → HI = 0x40, LO = 0x00; `done` in cycle 10.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_DIV   = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        SIGN = 2'b10
    } mdu_state_e;

    function automatic int cnt_width(input int nbits);
        return $clog2(nbits) + 1;
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial subtract for divide.
module mdu_step #(
    parameter int NBits = 32
) (
    input  logic             is_div,
    input  logic [NBits:0]   work_hi,
    input  logic [NBits-1:0] work_lo,
    input  logic [NBits-1:0] operand_b,
    output logic [NBits:0]   next_hi,
    output logic [NBits-1:0] next_lo
);

    logic [NBits:0]   sum;
    logic [NBits:0]   shifted;
    logic [NBits+1:0] diff;

    always_comb begin
        sum     = work_hi + (work_lo[0] ? {1'b0, operand_b} : '0);
        shifted = {work_hi[NBits-1:0], work_lo[NBits-1]};
        diff    = {1'b0, shifted} - {2'b00, operand_b};
        next_hi = '0;
        next_lo = '0;
        if (is_div) begin
            // A borrow out of the trial subtract means the divisor did not fit.
            if (diff[NBits+1]) begin
                next_hi = shifted;
                next_lo = {work_lo[NBits-2:0], 1'b0};
            end else begin
                next_hi = diff[NBits:0];
                next_lo = {work_lo[NBits-2:0], 1'b1};
            end
        end else begin
            next_hi = {1'b0, sum[NBits:1]};
            next_lo = {sum[0], work_lo[NBits-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers for the MIPS EX stage.
module mult_div_unit #(
    parameter int NBits = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [NBits-1:0] OperandA,
    input  logic [NBits-1:0] OperandB,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [NBits-1:0] WriteData,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [NBits-1:0] HI,
    output logic [NBits-1:0] LO
);
    import mdu_pkg::*;

    localparam int CntW = cnt_width(NBits);

    mdu_state_e       state;
    logic [CntW-1:0]  cnt;
    mdu_op_e          op_r;
    logic             neg_res, neg_rem;
    logic [NBits:0]   work_hi;
    logic [NBits-1:0] work_lo, mag_b, a_raw;
    logic [NBits:0]   step_hi;
    logic [NBits-1:0] step_lo;
    logic             is_signed, is_div_r, a_neg, b_neg;

    function automatic logic [NBits-1:0] cond_neg(input logic [NBits-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*NBits-1:0] cond_neg_wide(input logic [2*NBits-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign is_signed = (op == MDU_MULT) || (op == MDU_DIV);
    assign a_neg     = is_signed & OperandA[NBits-1];
    assign b_neg     = is_signed & OperandB[NBits-1];
    assign is_div_r  = (op_r == MDU_DIVU) || (op_r == MDU_DIV);

    mdu_step #(.NBits(NBits)) u_step (
        .is_div    (is_div_r),
        .work_hi   (work_hi),
        .work_lo   (work_lo),
        .operand_b (mag_b),
        .next_hi   (step_hi),
        .next_lo   (step_lo)
    );

    // Datapath: operands are captured every IDLE cycle, so the last one before CALC wins.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            op_r    <= mdu_op_e'(op);
            a_raw   <= OperandA;
            mag_b   <= b_neg ? -OperandB : OperandB;
            work_hi <= '0;
            work_lo <= a_neg ? -OperandA : OperandA;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
        end else if (state == CALC) begin
            work_hi <= step_hi;
            work_lo <= step_lo;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            HI          <= '0;
            LO          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) HI <= WriteData;
                    if (lo_we) LO <= WriteData;
                    if (start && !flush) begin
                        state <= CALC;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (cnt == CntW'(NBits - 1)) state <= SIGN;
                        cnt <= cnt + CntW'(1);
                    end
                end
                SIGN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!flush) begin
                        done <= 1'b1;
                        if (!is_div_r) begin
                            {HI, LO} <= cond_neg_wide({work_hi[NBits-1:0], work_lo}, neg_res);
                        end else if (mag_b == '0) begin
                            // Divide by zero: quotient saturates, dividend passes through untouched.
                            LO          <= '1;
                            HI          <= a_raw;
                            div_by_zero <= 1'b1;
                        end else begin
                            LO <= cond_neg(work_lo, neg_res);
                            HI <= cond_neg(work_hi[NBits-1:0], neg_rem);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
